tag_init_sequencer: RTL

- Autonomous tag-array initializer for the non-blocking cache (bsg_cache_nb).
- On start, it walks every (way, set) and issues TAGST with zero data, which clears tag, valid and lock.
- It then optionally walks again with TAGLV and checks every response reads back valid=0, lock=0.
- It sits in front of the cache packet input during bring-up and flush, with a bounded number of packets outstanding.

---
 rtl/tag_init_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/tag_init_sequencer.sv
// Tag-array initializer for bsg_cache_nb: clears every (way, set) with TAGST,
// then optionally reads each back with TAGLV and flags any valid/lock bit left set.
module tag_init_sequencer #(
  parameter int addr_width_p          = 32,
  parameter int word_width_p          = 32,
  parameter int src_id_width_p        = 4,
  parameter int ways_p                = 2,
  parameter int sets_p                = 4,
  parameter int block_size_in_words_p = 4,
  parameter int src_id_p              = 1,
  parameter int max_outstanding_p     = 4,
  parameter int verify_p              = 1,
  localparam int block_offset_width_lp = $clog2(word_width_p/8) + $clog2(block_size_in_words_p),
  localparam int lg_ways_lp            = (ways_p > 1) ? $clog2(ways_p) : 1,
  localparam int lg_sets_lp            = (sets_p > 1) ? $clog2(sets_p) : 1,
  localparam int mask_width_lp         = word_width_p/8,
  localparam int opcode_width_lp       = 6,
  localparam int bsg_cache_nb_pkt_width_lp =
    src_id_width_p + opcode_width_lp + addr_width_p + word_width_p + mask_width_lp
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 start_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 error_o,
  output logic                                 v_o,
  output logic [bsg_cache_nb_pkt_width_lp-1:0] cache_pkt_o,
  input  logic                                 yumi_i,
  input  logic                                 v_i,
  input  logic [word_width_p-1:0]              data_i,
  input  logic [src_id_width_p-1:0]            src_id_i,
  output logic                                 yumi_o
);

  localparam int cnt_width_lp = lg_ways_lp + lg_sets_lp;
  localparam int out_width_lp = $clog2(max_outstanding_p + 1);

  localparam logic [cnt_width_lp-1:0]    last_cnt_lp = cnt_width_lp'(ways_p*sets_p - 1);
  localparam logic [out_width_lp-1:0]    max_out_lp  = out_width_lp'(max_outstanding_p);
  localparam logic [src_id_width_p-1:0]  src_id_lp   = src_id_width_p'(src_id_p);
  localparam logic [opcode_width_lp-1:0] tagst_lp    = 6'b010000;
  localparam logic [opcode_width_lp-1:0] taglv_lp    = 6'b010010;

  typedef enum logic [2:0] {IDLE, ST, DRAIN_ST, LV, DRAIN_LV, FINISH} state_e;

  state_e                       r_state;
  state_e                       w_next_state;
  logic [cnt_width_lp-1:0]      r_cnt;
  logic [out_width_lp-1:0]      r_outstanding;
  logic [out_width_lp-1:0]      w_out_next;
  logic                         r_error;
  logic                         w_issue;
  logic                         w_resp;
  logic                         w_last;
  logic [opcode_width_lp-1:0]   w_opcode;
  logic [addr_width_p-1:0]      w_addr;
  logic [lg_ways_lp-1:0]        w_way;
  logic [lg_sets_lp-1:0]        w_set;
  logic                         w_unused_data;

  assign w_unused_data = ^data_i[word_width_p-1:2];

  assign yumi_o  = v_i;
  assign error_o = r_error;
  assign w_issue = v_o & yumi_i;
  assign w_resp  = v_i && (src_id_i == src_id_lp) && (r_outstanding != '0);
  assign w_last  = (r_cnt == last_cnt_lp);

  always_comb begin
    w_out_next = r_outstanding;
    case ({w_issue, w_resp})
      2'b10:   w_out_next = r_outstanding + 1'b1;
      2'b01:   w_out_next = r_outstanding - 1'b1;
      default: w_out_next = r_outstanding;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Drain states wait on the post-update count so a final response and the
  // transition land in the same cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (start_i) w_next_state = ST;
      ST:       if (w_issue && w_last) w_next_state = DRAIN_ST;
      DRAIN_ST: if (w_out_next == '0) w_next_state = (verify_p != 0) ? LV : FINISH;
      LV:       if (w_issue && w_last) w_next_state = DRAIN_LV;
      DRAIN_LV: if (w_out_next == '0) w_next_state = FINISH;
      FINISH:   w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (r_state != IDLE);
    done_o   = (r_state == FINISH);
    v_o      = ((r_state == ST) || (r_state == LV)) && (r_outstanding < max_out_lp);
    w_opcode = (r_state == LV) ? taglv_lp : tagst_lp;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt         <= '0;
      r_outstanding <= '0;
      r_error       <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      if ((r_state == IDLE) && start_i) begin
        r_cnt   <= '0;
        r_error <= 1'b0;
      end else if (w_issue) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (((r_state == LV) || (r_state == DRAIN_LV)) && w_resp && (data_i[1:0] != 2'b00))
        r_error <= 1'b1;
    end
  end

  assign w_way = r_cnt[cnt_width_lp-1 -: lg_ways_lp];
  assign w_set = r_cnt[lg_sets_lp-1:0];

  always_comb begin
    w_addr = '0;
    w_addr[block_offset_width_lp +: lg_sets_lp]              = w_set;
    w_addr[block_offset_width_lp + lg_sets_lp +: lg_ways_lp] = w_way;
  end

  assign cache_pkt_o = {src_id_lp, w_opcode, w_addr, {word_width_p{1'b0}}, {mask_width_lp{1'b0}}};

endmodule
